// File: rtl/lb_drain_if.sv
// Bundles the drain-request, line-buffer R0 read port and beat-stream signals of lb_drain_ctrl.
// slave is the controller's view; master is the view of the surrounding environment.
interface lb_drain_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4,
    parameter int ID_W   = 4
);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LINE_W = ADDR_W - BEAT_W;

    logic              req_valid;
    logic              req_ready;
    logic [LINE_W-1:0] req_line;
    logic [BEAT_W-1:0] req_beat;
    logic [ID_W-1:0]   req_id;

    logic [ADDR_W-1:0] R0_addr;
    logic              R0_en;
    logic [DATA_W-1:0] R0_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [BEAT_W-1:0] out_beat;
    logic              out_last;
    logic [ID_W-1:0]   out_id;

    logic              busy;

    modport slave (
        input  req_valid, req_line, req_beat, req_id, R0_data, out_ready,
        output req_ready, R0_addr, R0_en, out_valid, out_data, out_beat, out_last, out_id, busy
    );

    modport master (
        output req_valid, req_line, req_beat, req_id, R0_data, out_ready,
        input  req_ready, R0_addr, R0_en, out_valid, out_data, out_beat, out_last, out_id, busy
    );
endinterface

// File: rtl/lb_drain_ctrl.sv
// Line-buffer drain controller: reads one line beat-by-beat over R0 into a 2-entry FIFO and streams it out.
// Optional LB_DRAIN_CRIT_FIRST_EN: start the drain at req_beat and wrap; otherwise always start at beat 0.
module lb_drain_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4,
    parameter int ID_W   = 4
) (
    input  logic      clk,
    input  logic      rst,
    lb_drain_if.slave bus
);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LINE_W = ADDR_W - BEAT_W;

    typedef enum logic {IDLE, READ} state_t;

    state_t            state_reg, state_next;
    logic [LINE_W-1:0] line_reg, line_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic [BEAT_W-1:0] cnt_reg, cnt_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic              ready_en_reg;
    logic [1:0]        occ_reg, occ_next;
    logic              wr_ptr_reg, rd_ptr_reg;

    logic [DATA_W-1:0] data_mem [2];
    logic [BEAT_W-1:0] beat_mem [2];
    logic              last_mem [2];
    logic [ID_W-1:0]   id_mem   [2];

    logic              head_valid;
    logic              pop;
    logic              room;
    logic              issue;
    logic              issue_last;
    logic [BEAT_W-1:0] start_beat;

`ifdef LB_DRAIN_CRIT_FIRST_EN
    assign start_beat = bus.req_beat;
`else
    assign start_beat = '0;
`endif

    assign head_valid = (occ_reg != 2'd0);
    assign pop        = head_valid & bus.out_ready;
    // A slot freed by this cycle's pop can be refilled in the same cycle.
    assign room       = (occ_reg - {1'b0, pop}) < 2'd2;

    always_comb begin
        state_next = state_reg;
        line_next  = line_reg;
        beat_next  = beat_reg;
        cnt_next   = cnt_reg;
        id_next    = id_reg;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ready_en_reg && bus.req_valid) begin
                    line_next  = bus.req_line;
                    id_next    = bus.req_id;
                    beat_next  = start_beat;
                    cnt_next   = '0;
                    state_next = READ;
                end
            end
            READ: begin
                if (room) begin
                    issue      = 1'b1;
                    issue_last = (cnt_reg == BEAT_W'(BEATS - 1));
                    beat_next  = beat_reg + BEAT_W'(1);
                    cnt_next   = cnt_reg + BEAT_W'(1);
                    if (issue_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        occ_next = occ_reg;
        case ({issue, pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            line_reg     <= '0;
            beat_reg     <= '0;
            cnt_reg      <= '0;
            id_reg       <= '0;
            ready_en_reg <= 1'b0;
            occ_reg      <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            line_reg     <= line_next;
            beat_reg     <= beat_next;
            cnt_reg      <= cnt_next;
            id_reg       <= id_next;
            ready_en_reg <= 1'b1;
            occ_reg      <= occ_next;
            if (issue) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)   rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (issue) begin
            data_mem[wr_ptr_reg] <= bus.R0_data;
            beat_mem[wr_ptr_reg] <= beat_reg;
            last_mem[wr_ptr_reg] <= issue_last;
            id_mem[wr_ptr_reg]   <= id_reg;
        end
    end

    assign bus.req_ready = (state_reg == IDLE) & ready_en_reg;
    assign bus.R0_en     = issue;
    assign bus.R0_addr   = issue ? {line_reg, beat_reg} : '0;
    assign bus.out_valid = head_valid;
    assign bus.out_data  = data_mem[rd_ptr_reg];
    assign bus.out_beat  = beat_mem[rd_ptr_reg];
    assign bus.out_last  = last_mem[rd_ptr_reg];
    assign bus.out_id    = id_mem[rd_ptr_reg];
    assign bus.busy      = (state_reg != IDLE) | head_valid;
endmodule

// File: tb/tb_lb_drain_ctrl.sv
// Bench for lb_drain_ctrl: cycle tables for the basic drain cases, hand sequences for the corners,
// and a random run checked by a queue-based scoreboard that watches every read and every popped beat.
module tb_lb_drain_ctrl;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;
    localparam int ID_W   = 4;
    localparam int BEAT_W = 2;
    localparam int LINE_W = 3;
    localparam logic [DATA_W-1:0] GARBAGE = {4{32'hDEADBEEF}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lb_drain_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .ID_W(ID_W)) bus ();

    lb_drain_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .ID_W(ID_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Memory model: data only appears while R0_en is high, otherwise a poison pattern.
    logic [DATA_W-1:0] mem [32];
    assign bus.R0_data = bus.R0_en ? mem[bus.R0_addr] : GARBAGE;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BEAT_W-1:0] beat;
        logic              last;
        logic [ID_W-1:0]   id;
    } beat_t;

    beat_t exp_q[$];
    int    rd_q[$];
    int    issued = 0;
    int    popped = 0;
    int    n_last = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int line, input int beat, input int id);
        bit acc;
        acc = 1'b0;
        bus.req_line  = LINE_W'(line);
        bus.req_beat  = BEAT_W'(beat);
        bus.req_id    = ID_W'(id);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus.req_ready;
            tick();
        end
        bus.req_valid = 1'b0;
        if (!acc) chk("req_accept_timeout", acc, 1);
    endtask

    task automatic wait_idle(input int max);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (exp_q.size() == 0 && rd_q.size() == 0 && !bus.busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("drain_timeout", done, 1);
    endtask

    // Scoreboard: each accepted request expands into BEATS reads and BEATS output beats.
    initial begin : monitor
        beat_t prev, cur, e;
        bit    hold, pop, room;
        int    buffered, st, b, a;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                rd_q.delete();
                issued = 0;
                popped = 0;
                hold   = 1'b0;
                continue;
            end
            cur = {bus.out_data, bus.out_beat, bus.out_last, bus.out_id};
            pop = bus.out_valid & bus.out_ready;
            if (hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_payload", cur, prev);
            end
            buffered = issued - popped;
            if (pop) begin
                if (exp_q.size() == 0) chk("beat_queue_size", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("beat", cur, e);
                end
                popped++;
                if (bus.out_last) n_last++;
            end
            room = (buffered - int'(pop)) < 2;
            if (bus.R0_en) begin
                if (rd_q.size() == 0) chk("read_queue_size", rd_q.size(), 1);
                else chk("read_addr", bus.R0_addr, rd_q.pop_front());
                chk("read_room", room, 1);
                issued++;
            end else if (rd_q.size() != 0 && room) begin
                chk("read_stall", bus.R0_en, 1);
            end
            if (bus.req_valid && bus.req_ready) begin
`ifdef LB_DRAIN_CRIT_FIRST_EN
                st = int'(bus.req_beat);
`else
                st = 0;
`endif
                for (int i = 0; i < BEATS; i++) begin
                    b = (st + i) % BEATS;
                    a = int'(bus.req_line) * BEATS + b;
                    rd_q.push_back(a);
                    exp_q.push_back({mem[a], BEAT_W'(b), (i == BEATS - 1), bus.req_id});
                end
            end
            hold = bus.out_valid & ~bus.out_ready;
            prev = cur;
        end
    end

    typedef struct {
        bit                rr;
        bit                rdy;
        bit                en;
        int                addr;
        bit                ov;
        logic [DATA_W-1:0] data;
        int                beat;
        bit                last;
        bit                busy;
    } vec_t;

    vec_t tv [15];

    function automatic vec_t v(bit rr, bit rdy, bit en, int addr, bit ov, int k, int beat, bit last, bit busy);
        vec_t r;
        logic [DATA_W-1:0] d;
        d = DATA_W'(k);
        r.rr = rr; r.rdy = rdy; r.en = en; r.addr = addr; r.ov = ov;
        r.data = d * 128'h1111; r.beat = beat; r.last = last; r.busy = busy;
        return r;
    endfunction

    task automatic run_table(input int first, input int n, input int id);
        for (int i = first; i < first + n; i++) begin
            bus.out_ready = tv[i].rdy;
            #1;
            chk($sformatf("row%0d_req_ready", i), bus.req_ready, tv[i].rr);
            chk($sformatf("row%0d_R0_en", i), bus.R0_en, tv[i].en);
            if (tv[i].en) chk($sformatf("row%0d_R0_addr", i), bus.R0_addr, tv[i].addr);
            chk($sformatf("row%0d_out_valid", i), bus.out_valid, tv[i].ov);
            if (tv[i].ov)
                chk($sformatf("row%0d_out", i), {bus.out_data, bus.out_beat, bus.out_last, bus.out_id},
                    {tv[i].data, BEAT_W'(tv[i].beat), tv[i].last, ID_W'(id)});
            chk($sformatf("row%0d_busy", i), bus.busy, tv[i].busy);
            tick();
        end
    endtask

    int p0, l0, exp5 [4];
    bit ok, drv_done;

    initial begin
        // 1: straight drain of line 3 at full rate
        tv[0]  = v(0, 1, 1, 12, 0,  0, 0, 0, 1);
        tv[1]  = v(0, 1, 1, 13, 1, 12, 0, 0, 1);
        tv[2]  = v(0, 1, 1, 14, 1, 13, 1, 0, 1);
        tv[3]  = v(0, 1, 1, 15, 1, 14, 2, 0, 1);
        tv[4]  = v(1, 1, 0,  0, 1, 15, 3, 1, 1);
        tv[5]  = v(1, 1, 0,  0, 0,  0, 0, 0, 0);
        // 2: consumer stalled right after accept, then released
        tv[6]  = v(0, 0, 1, 12, 0,  0, 0, 0, 1);
        tv[7]  = v(0, 0, 1, 13, 1, 12, 0, 0, 1);
        tv[8]  = v(0, 0, 0,  0, 1, 12, 0, 0, 1);
        tv[9]  = v(0, 0, 0,  0, 1, 12, 0, 0, 1);
        tv[10] = v(0, 1, 1, 14, 1, 12, 0, 0, 1);
        tv[11] = v(0, 1, 1, 15, 1, 13, 1, 0, 1);
        tv[12] = v(1, 1, 0,  0, 1, 14, 2, 0, 1);
        tv[13] = v(1, 1, 0,  0, 1, 15, 3, 1, 1);
        tv[14] = v(1, 1, 0,  0, 0,  0, 0, 0, 0);
`ifdef LB_DRAIN_CRIT_FIRST_EN
        exp5 = '{7, 4, 5, 6};
`else
        exp5 = '{4, 5, 6, 7};
`endif

        for (int k = 0; k < 32; k++) mem[k] = DATA_W'(k) * 128'h1111;
        bus.req_valid = 1'b0;
        bus.req_line  = '0;
        bus.req_beat  = '0;
        bus.req_id    = '0;
        bus.out_ready = 1'b1;

        #2;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_R0_en", bus.R0_en, 0);
        chk("reset_R0_addr", bus.R0_addr, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("release_req_ready_before_clk", bus.req_ready, 0);
        tick();
        chk("release_req_ready", bus.req_ready, 1);

        send_req(3, 0, 5);
        run_table(0, 6, 5);
        send_req(3, 0, 5);
        run_table(6, 9, 5);

        // 3: back-to-back lines 0 and 7 with out_ready toggling every cycle
        p0 = popped;
        l0 = n_last;
        ok = 1'b0;
        fork
            begin
                send_req(0, 0, 1);
                send_req(7, 0, 2);
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    bus.out_ready = (i % 2 == 0);
                    tick();
                    if (popped - p0 >= 8) begin
                        ok = 1'b1;
                        break;
                    end
                end
            end
        join
        chk("t3_done", ok, 1);
        chk("t3_busy_after_last_pop", bus.busy, 0);
        chk("t3_beats", popped - p0, 8);
        chk("t3_lasts", n_last - l0, 2);
        bus.out_ready = 1'b1;
        wait_idle(20);

        // 4: asynchronous reset after beat 1 has been popped
        send_req(3, 0, 5);
        tick();
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("t4_out_valid", bus.out_valid, 0);
        chk("t4_R0_en", bus.R0_en, 0);
        chk("t4_busy", bus.busy, 0);
        chk("t4_req_ready", bus.req_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t4_req_ready_before_clk", bus.req_ready, 0);
        tick();
        chk("t4_req_ready_after_clk", bus.req_ready, 1);
        p0 = popped;
        send_req(2, 0, 9);
        wait_idle(20);
        chk("t4_beats", popped - p0, 4);

        // 5: critical-beat request, addresses depend on the build option
        send_req(1, 3, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_R0_en%0d", i), bus.R0_en, 1);
            chk($sformatf("t5_R0_addr%0d", i), bus.R0_addr, exp5[i]);
            tick();
        end
        wait_idle(20);

        // 6: random contents, requests and backpressure
        for (int k = 0; k < 32; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
        p0 = popped;
        drv_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 200; n++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    bus.out_ready = ($urandom_range(0, 9) < 6);
                    tick();
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_idle(50);
        chk("t6_beats", popped - p0, 800);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end
endmodule
